// File: rtl/cndm_micro_tx_sched.sv
// Round-robin transmit scheduler for a Corundum-micro port.
// It keeps a host producer pointer and an internal scheduled pointer for each
// transmit queue. It offers one descriptor-fetch request at a time to the port
// TX engine. A global in-flight limit is returned to the pool by TX completions.
module cndm_micro_tx_sched #(
   parameter int QUEUES       = 4,
   parameter int PTR_W        = 16,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [QUEUES-1:0]         q_enable,
   input  logic                      db_valid,
   input  logic [$clog2(QUEUES)-1:0] db_queue,
   input  logic [PTR_W-1:0]          db_prod,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic [$clog2(QUEUES)-1:0] req_queue,
   output logic [PTR_W-1:0]          req_index,
   input  logic                      cpl_valid,
   output logic [7:0]                inflight,
   output logic                      busy,
   output logic                      cpl_err
);

   localparam int         CL_Q    = $clog2(QUEUES);
   localparam logic [7:0] MAX_INF = 8'(MAX_INFLIGHT);

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  prod_q  [QUEUES];
   logic [PTR_W-1:0]  prod_d  [QUEUES];
   logic [PTR_W-1:0]  sched_q [QUEUES];
   logic [PTR_W-1:0]  sched_d [QUEUES];
   logic [CL_Q-1:0]   last_grant_q, last_grant_d;
   logic              req_valid_q, req_valid_d;
   logic [CL_Q-1:0]   req_queue_q, req_queue_d;
   logic [PTR_W-1:0]  req_index_q, req_index_d;
   logic [7:0]        inflight_q, inflight_d;
   logic              cpl_err_q, cpl_err_d;

   logic [QUEUES-1:0] elig;
   logic              win_found;
   logic [CL_Q-1:0]   win_queue;
   logic              handshake;
   logic              cpl_ok;

   assign handshake = req_valid_q && req_ready;
   assign cpl_ok    = cpl_valid && (inflight_q != 8'd0);

   // A queue has work when it is enabled and its producer pointer differs
   // from its scheduled pointer. Pointer wrap needs no special handling.
   always_comb begin
      elig = '0;
      for (int q = 0; q < QUEUES; q++) begin
         elig[q] = q_enable[q] && (prod_q[q] != sched_q[q]);
      end
   end

   // Round-robin search. It starts one past the last granted queue and wraps
   // naturally in the CL_Q-bit index.
   always_comb begin
      logic [CL_Q-1:0] cand;
      // NOTE: every variable written here gets a default first, so no latch is
      // inferred on paths where the search finds nothing.
      cand      = '0;
      win_found = 1'b0;
      win_queue = '0;
      for (int i = 1; i <= QUEUES; i++) begin
         cand = last_grant_q + CL_Q'(i);
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_queue = cand;
         end
      end
   end

   // Next-state, request and pointer/credit bookkeeping.
   always_comb begin
      // NOTE: blocking assignments are right in combinational logic, because later
      // statements override the defaults. Only the clocked block uses <=.
      state_d      = state_q;
      prod_d       = prod_q;
      sched_d      = sched_q;
      last_grant_d = last_grant_q;
      req_valid_d  = req_valid_q;
      req_queue_d  = req_queue_q;
      req_index_d  = req_index_q;
      inflight_d   = inflight_q;
      cpl_err_d    = cpl_err_q;

      // A doorbell always lands, even on a disabled queue or a queue being
      // handshaken. A doorbell back to sched simply cancels the queue's work.
      if (db_valid) begin
         prod_d[db_queue] = db_prod;
      end

      case (state_q)
         IDLE: begin
            if (win_found && (inflight_q < MAX_INF)) begin
               state_d     = REQ;
               req_valid_d = 1'b1;
               req_queue_d = win_queue;
               req_index_d = sched_q[win_queue];
            end
         end
         REQ: begin
            // The offer stays put until accepted, whatever happens to
            // q_enable or the producer pointers in the meantime.
            if (handshake) begin
               state_d              = IDLE;
               req_valid_d          = 1'b0;
               sched_d[req_queue_q] = sched_q[req_queue_q] + PTR_W'(1);
               last_grant_d         = req_queue_q;
            end
         end
         default: state_d = IDLE;
      endcase

      // A completion with nothing outstanding is flagged and does not touch the count.
      if (cpl_valid && (inflight_q == 8'd0)) begin
         cpl_err_d = 1'b1;
      end
      case ({handshake, cpl_ok})
         2'b10:   inflight_d = inflight_q + 8'd1;
         2'b01:   inflight_d = inflight_q - 8'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= CL_Q'(QUEUES - 1);
         req_valid_q  <= 1'b0;
         req_queue_q  <= '0;
         req_index_q  <= '0;
         inflight_q   <= 8'd0;
         cpl_err_q    <= 1'b0;
         // NOTE: the pointer arrays are plain flops, not RAM. They must be
         // cleared because prod == sched is what defines an empty queue.
         for (int q = 0; q < QUEUES; q++) begin
            prod_q[q]  <= '0;
            sched_q[q] <= '0;
         end
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         req_valid_q  <= req_valid_d;
         req_queue_q  <= req_queue_d;
         req_index_q  <= req_index_d;
         inflight_q   <= inflight_d;
         cpl_err_q    <= cpl_err_d;
         prod_q       <= prod_d;
         sched_q      <= sched_d;
      end
   end

   assign req_valid = req_valid_q;
   assign req_queue = req_queue_q;
   assign req_index = req_index_q;
   assign inflight  = inflight_q;
   assign cpl_err   = cpl_err_q;
   assign busy      = (inflight_q != 8'd0) || req_valid_q;

endmodule

// File: doc/cndm_micro_tx_sched.md
Name: cndm_micro_tx_sched

Overview:
- Round-robin transmit scheduler for a Corundum-micro port.
- Tracks host producer pointers (doorbells) and internal scheduled pointers for QUEUES transmit queues.
- Issues one descriptor-fetch request at a time to the port TX engine.
- Enforces a global in-flight limit, released by TX completions; sits between the port register block and the TX DMA/descriptor engine.

Parameters:
- QUEUES, 4, number of transmit queues (power of two, >=2).
- PTR_W, 16, producer/scheduled pointer width; arithmetic is modulo 2^PTR_W.
- MAX_INFLIGHT, 4, maximum outstanding requests without completion (1..255).
- CL_Q, $clog2(QUEUES), queue index width (derived, not overridable).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- q_enable  input  QUEUES  per-queue enable, level.
- db_valid  input  1  doorbell strobe, one cycle per event.
- db_queue  input  CL_Q  doorbell target queue.
- db_prod  input  PTR_W  new producer pointer for db_queue.
- req_valid  output  1  request valid.
- req_ready  input  1  TX engine accepts request.
- req_queue  output  CL_Q  queue of request.
- req_index  output  PTR_W  descriptor index (scheduled pointer of req_queue).
- cpl_valid  input  1  one TX completion, one cycle per event.
- inflight  output  8  current outstanding request count.
- busy  output  1  high when inflight!=0 or req_valid.
- cpl_err  output  1  sticky: completion received with inflight==0.

Behaviour:
- Reset is synchronous and active-high, sampled on rising clk. While rst is high:
  - all prod[q] and sched[q] cleared to 0; last_grant set to QUEUES-1.
  - req_valid=0, req_queue=0, req_index=0, inflight=0, busy=0, cpl_err=0; state=IDLE.
  - A pending request is dropped; no handshake is reported.
- Doorbell: on db_valid, prod[db_queue] <= db_prod at that edge, regardless of q_enable.
- Eligibility, from registers only: elig[q] = q_enable[q] && (prod[q] != sched[q]).
  - Wrap is implicit: prod=0x0002 with sched=0xFFFE is eligible.
- Arbitration: the first eligible queue searched from last_grant+1 upward, wrapping modulo QUEUES.
- State IDLE:
  - If any elig and inflight < MAX_INFLIGHT: at the edge, go to REQ.
  - Register req_valid=1, req_queue=winner, req_index=sched[winner].
  - Otherwise stay in IDLE.
- State REQ:
  - req_valid, req_queue and req_index are held stable until req_ready.
  - The request is not withdrawn if q_enable drops or a doorbell arrives.
  - On handshake (req_valid && req_ready) at an edge: sched[req_queue] += 1 (wraps), inflight += 1, last_grant <= req_queue, req_valid <= 0, go to IDLE.
- Throughput: at most one request per 2 cycles.
- Latency: db_valid sampled at edge E1 gives req_valid high after edge E2 (idle scheduler, queue enabled, credit available).
- Completion: cpl_valid with inflight>0 decrements inflight. With inflight==0: counter unchanged, cpl_err <= 1 (sticky until rst).
- Simultaneous events:
  - Handshake and cpl_valid in the same cycle: inflight unchanged (net 0).
  - Doorbell and handshake on the same queue: both apply (prod <= db_prod, sched += 1).
  - Eligibility is recomputed in the following IDLE cycle.
- Doorbell that moves prod back to equal sched cancels the queue's pending work. No error is raised.
- Disabled queue: pointers retained, not arbitrated; it resumes from sched[q] when re-enabled.
- busy is combinational from registered inflight and req_valid.

Test Plan:
- Reset, then doorbell q1 prod=3, all enabled, req_ready=1 -> requests (q1,0),(q1,1),(q1,2) on cycles 2,4,6; then idle; inflight=3.
- Doorbells q0 prod=2, q2 prod=2, q3 prod=1 together; MAX_INFLIGHT=8; completions echoed -> grant order q0,q2,q3,q0,q2 with indices 0,0,0,1,1.
- MAX_INFLIGHT=4, q0 prod=6, no completions -> exactly 4 requests, inflight=4, req_valid stays 0. One cpl_valid -> fifth request (q0,4) issues.
- Wrap: set sched[q2]=0xFFFE via 0xFFFE prior requests (or preload by doorbell sequence), prod=0x0001 -> requests with indices 0xFFFE,0xFFFF,0x0000, then stop.
- req_ready held 0 for 10 cycles while q_enable[1] drops mid-request -> req_valid/queue/index stable throughout. The request completes on ready; no further q1 requests until re-enabled.
- cpl_valid with inflight=0 -> cpl_err=1, inflight stays 0. Assert rst mid-REQ -> next cycle req_valid=0, inflight=0, cpl_err=0.
